mux_serializer_ctrl: RTL and testbench
======================================

Name: mux_serializer_ctrl

Overview:
Sequencer that turns the 32:1 bit multiplexer into a parallel-to-serial engine. It latches a 32-bit word and holds it on the mux data inputs. It then steps the 5-bit mux select through a programmable range, one bit per accepted beat. The selected mux output is returned to the block and presented as a valid/ready bit stream, used by the ALU project's serial debug/transmit path.

Parameters:
WIDTH, 32, word width; must equal the mux input count.
SEL_W, 5, select width; log2(WIDTH).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  new word offered
load_ready  out  1  block can accept a word (high only in IDLE)
load_data  in  32  word to serialize
load_len  in  5  number of bits minus 1 (0 -> 1 bit, 31 -> 32 bits)
load_msb_first  in  1  1: start at bit load_len, count down; 0: start at bit 0, count up
abort  in  1  synchronous abort of current transfer
mux_word  out  32  registered word, drives mux data inputs
mux_sel  out  5  registered select, drives mux select
mux_out  in  1  selected bit returned from the mux
ser_data  out  1  serial bit (mux_out in SHIFT; see Optional Feature)
ser_valid  out  1  ser_data is valid
ser_ready  in  1  consumer accepts the beat
ser_last  out  1  current beat is the final beat of the word
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n is low:
  - state=IDLE; mux_word=0; mux_sel=0; count=0; len_q=0; dir_q=0.
  - Outputs: ser_valid=0, ser_last=0, busy=0, load_ready=1. load_ready is decoded from IDLE.
  - Reset asserted mid-transfer discards the word immediately; no further beats are issued.
- States: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - load_ready=1, ser_valid=0.
  - On load_valid and load_ready: capture load_data into mux_word, load_len into len_q and load_msb_first into dir_q. Set count=0. Set mux_sel to load_len if msb_first, else to 0. Go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_data=mux_out, ser_last=(count==len_q).
  - A beat completes on ser_valid and ser_ready.
  - Beat completes with count!=len_q: count+1, and mux_sel-1 (msb_first) or mux_sel+1 (lsb_first).
  - Beat completes with count==len_q: go to IDLE (or PARITY). mux_sel and mux_word hold their last values.
  - ser_ready low: mux_sel, count and ser_data hold. No bit is dropped or repeated.
- Select arithmetic is 5-bit unsigned. By construction mux_sel never wraps: it stays within 0..len_q.
- Latency:
  - Load accepted in cycle N -> first ser_valid in cycle N+1.
  - Throughput is 1 bit/cycle with ser_ready held high. A word of L+1 bits takes L+1 beats.
  - There is a 1-cycle IDLE bubble between words, because load_ready is low in SHIFT.
- abort:
  - In SHIFT or PARITY: next state is IDLE, and ser_valid is low from the next cycle.
  - If a beat handshake happens in the same cycle, the beat counts as delivered and the abort still wins.
  - In IDLE, abort has priority over load_valid; the word is not accepted that cycle.
- The mux itself is combinational, so mux_out is valid in the same cycle that mux_sel/mux_word are registered.

Optional Feature:
MUX_SER_PARITY_EN:
- Defined:
  - The PARITY state is added. parity_q is the running XOR of every delivered data bit and is cleared on load.
  - After the last data beat, the block goes to PARITY instead of IDLE: ser_valid=1, ser_data=parity_q (even parity), ser_last=1.
  - In PARITY, ser_last is 0 on the final data beat.
  - A handshake in PARITY -> IDLE.
- Not defined: no PARITY state and no parity_q register. ser_data is always mux_out.

Test Plan:
1. Load 0xA5A50F0F, len=31, lsb_first, ser_ready=1 -> 32 beats; mux_sel 0..31; ser_data equals bit[i]; ser_last only on beat 32; load_ready=1 the cycle after.
2. Load 0x000000C3, len=7, msb_first -> mux_sel 7,6,...,0; ser_data 1,1,0,0,0,0,1,1; ser_last on 8th beat.
3. Load 0x0000FFFF, len=15, ser_ready pattern 1,0,0,1,0,1... -> mux_sel advances only on handshake; exactly 16 ones delivered.
4. len=0, data 0x1 -> single beat with ser_data=1 and ser_last=1; load_valid held high -> next word accepted after 1 idle cycle.
5. abort at beat 5 of a 32-bit word -> ser_valid=0 and busy=0 next cycle; a new load is then accepted. Separately, rst_n pulsed low mid-transfer -> outputs at reset values immediately, without waiting for clk.
6. MUX_SER_PARITY_EN defined, data 0x7, len=3, lsb_first -> beats 1,1,1,0, then parity beat 1 with ser_last=1; without the macro, 4 beats with ser_last on the 4th.

Source files
------------

// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial sequencer around an external 32:1 bit mux. It holds a word on the mux data
// inputs and walks the select across a programmable range. `MUX_SER_PARITY_EN adds an even-parity beat.
module mux_serializer_ctrl #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SEL_W-1:0] load_len,
    input  logic             load_msb_first,
    input  logic             abort,
    output logic [WIDTH-1:0] mux_word,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

`ifdef MUX_SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;
`endif

    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mux_word_q, mux_word_d;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic [SEL_W-1:0]   count_q, count_d;
    logic [SEL_W-1:0]   len_q, len_d;
    logic               dir_q, dir_d;
`ifdef MUX_SER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic beat;
    logic last_data;

    assign last_data  = (count_q == len_q);
    assign beat       = ser_valid & ser_ready;
    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign ser_valid  = (state_q != ST_IDLE);
    assign mux_word   = mux_word_q;
    assign mux_sel    = mux_sel_q;

`ifdef MUX_SER_PARITY_EN
    assign ser_data = (state_q == ST_PARITY) ? parity_q : mux_out;
    assign ser_last = (state_q == ST_PARITY);
`else
    assign ser_data = mux_out;
    assign ser_last = (state_q == ST_SHIFT) && last_data;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        mux_word_d = mux_word_q;
        mux_sel_d  = mux_sel_q;
        count_d    = count_q;
        len_d      = len_q;
        dir_d      = dir_q;
`ifdef MUX_SER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // abort outranks a pending load offered in the same cycle
                if (!abort && load_valid) begin
                    mux_word_d = load_data;
                    len_d      = load_len;
                    dir_d      = load_msb_first;
                    count_d    = '0;
                    mux_sel_d  = load_msb_first ? load_len : '0;
`ifdef MUX_SER_PARITY_EN
                    parity_d   = 1'b0;
`endif
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (beat) begin
`ifdef MUX_SER_PARITY_EN
                    parity_d = parity_q ^ mux_out;
`endif
                    if (last_data) begin
`ifdef MUX_SER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        count_d   = count_q + ONE;
                        mux_sel_d = dir_q ? (mux_sel_q - ONE) : (mux_sel_q + ONE);
                    end
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MUX_SER_PARITY_EN
            ST_PARITY: begin
                if (abort || beat) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mux_word_q <= '0;
            mux_sel_q  <= '0;
            count_q    <= '0;
            len_q      <= '0;
            dir_q      <= 1'b0;
`ifdef MUX_SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mux_word_q <= mux_word_d;
            mux_sel_q  <= mux_sel_d;
            count_q    <= count_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
`ifdef MUX_SER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Directed bench for mux_serializer_ctrl; the 32:1 mux is modelled inline so the
// serial stream can be compared against hand-computed bit sequences.
module tb_mux_serializer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [4:0]  load_len;
    logic        load_msb_first;
    logic        abort;
    logic [31:0] mux_word;
    logic [4:0]  mux_sel;
    logic        mux_out;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_out = mux_word[mux_sel];

    mux_serializer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_len       (load_len),
        .load_msb_first (load_msb_first),
        .abort          (abort),
        .mux_word       (mux_word),
        .mux_sel        (mux_sel),
        .mux_out        (mux_out),
        .ser_data       (ser_data),
        .ser_valid      (ser_valid),
        .ser_ready      (ser_ready),
        .ser_last       (ser_last),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [4:0] len, input logic msb);
        load_valid     = 1'b1;
        load_data      = d;
        load_len       = len;
        load_msb_first = msb;
        step();
        load_valid     = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic        exp2 [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        exp6 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int          pat [6]  = '{1, 0, 0, 1, 0, 1};
        int          k, ones, beats;
        logic [4:0]  exp_sel;

        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_len = '0;
        load_msb_first = 1'b0; abort = 1'b0; ser_ready = 1'b0;

        // reset state
        #12;
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_ser_valid",  32'(ser_valid),  32'd0);
        check("rst_ser_last",   32'(ser_last),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_mux_word",   mux_word,        32'd0);
        check("rst_mux_sel",    32'(mux_sel),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: 32 bits lsb-first with ser_ready held high
        ser_ready = 1'b1;
        w = 32'hA5A5_0F0F;
        do_load(w, 5'd31, 1'b0);
        for (int i = 0; i < 32; i++) begin
            check("t1_valid", 32'(ser_valid), 32'd1);
            check("t1_sel",   32'(mux_sel),   32'(i));
            check("t1_data",  32'(ser_data),  32'(w[i]));
            check("t1_last",  32'(ser_last),  32'(i == 31));
            step();
        end
        check("t1_load_ready_after", 32'(load_ready), 32'd1);
        check("t1_valid_after",      32'(ser_valid),  32'd0);
        check("t1_busy_after",       32'(busy),       32'd0);

        // 2: 8 bits msb-first
        do_load(32'h0000_00C3, 5'd7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t2_sel",  32'(mux_sel),  32'(7 - i));
            check("t2_data", 32'(ser_data), 32'(exp2[i]));
            check("t2_last", 32'(ser_last), 32'(i == 7));
            step();
        end
        check("t2_idle", 32'(busy), 32'd0);

        // 3: back-pressure with ready pattern 1,0,0,1,0,1,...
        do_load(32'h0000_FFFF, 5'd15, 1'b0);
        k = 0; ones = 0; beats = 0; exp_sel = 5'd0;
        while (busy && k < 200) begin
            ser_ready = pat[k % 6] != 0;
            check("t3_sel", 32'(mux_sel), 32'(exp_sel));
            if (ser_valid && ser_ready) begin
                ones += int'(ser_data);
                beats++;
                check("t3_last", 32'(ser_last), 32'(exp_sel == 5'd15));
                exp_sel = exp_sel + 5'd1;
            end
            step();
            k++;
        end
        check("t3_timeout", 32'(busy), 32'd0);
        check("t3_ones",    32'(ones),  32'd16);
        check("t3_beats",   32'(beats), 32'd16);
        ser_ready = 1'b1;

        // 4: single-bit word, load_valid held high across words
        load_valid = 1'b1; load_data = 32'h1; load_len = 5'd0; load_msb_first = 1'b0;
        step();
        check("t4_valid",      32'(ser_valid),  32'd1);
        check("t4_data",       32'(ser_data),   32'd1);
        check("t4_last",       32'(ser_last),   32'd1);
        check("t4_ready_busy", 32'(load_ready), 32'd0);
        step();
        check("t4_bubble_ready", 32'(load_ready), 32'd1);
        check("t4_bubble_valid", 32'(ser_valid),  32'd0);
        step();
        check("t4_second_valid", 32'(ser_valid), 32'd1);
        check("t4_second_word",  mux_word,       32'h1);
        load_valid = 1'b0;
        step();
        check("t4_done", 32'(busy), 32'd0);

        // 5a: abort on the fifth beat of a 32-bit word
        do_load(32'hFFFF_FFFF, 5'd31, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("t5_sel_beat5", 32'(mux_sel), 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_valid", 32'(ser_valid),  32'd0);
        check("t5_abort_busy",  32'(busy),       32'd0);
        check("t5_abort_ready", 32'(load_ready), 32'd1);
        do_load(32'h0000_00F0, 5'd3, 1'b1);
        check("t5_reload_word", mux_word,        32'h0000_00F0);
        check("t5_reload_sel",  32'(mux_sel),    32'd3);
        check("t5_reload_data", 32'(ser_data),   32'd0);
        for (int i = 0; i < 4; i++) step();
        check("t5_reload_done", 32'(busy), 32'd0);

        // 5b: abort outranks load in IDLE
        abort = 1'b1; load_valid = 1'b1; load_data = 32'h55;
        step();
        abort = 1'b0; load_valid = 1'b0;
        check("t5_idle_abort_busy", 32'(busy), 32'd0);
        check("t5_idle_abort_word", mux_word,  32'h0000_00F0);

        // 5c: asynchronous reset mid-transfer
        do_load(32'h1234_5678, 5'd31, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t5_arst_valid", 32'(ser_valid),  32'd0);
        check("t5_arst_busy",  32'(busy),       32'd0);
        check("t5_arst_ready", 32'(load_ready), 32'd1);
        check("t5_arst_last",  32'(ser_last),   32'd0);
        check("t5_arst_word",  mux_word,        32'd0);
        check("t5_arst_sel",   32'(mux_sel),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("t5_arst_stays_idle", 32'(ser_valid), 32'd0);

        // 6: 4-bit word, parity beat when compiled in
        do_load(32'h0000_0007, 5'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t6_valid", 32'(ser_valid), 32'd1);
            check("t6_data",  32'(ser_data),  32'(exp6[i]));
`ifdef MUX_SER_PARITY_EN
            check("t6_last",  32'(ser_last),  32'd0);
`else
            check("t6_last",  32'(ser_last),  32'(i == 3));
`endif
            step();
        end
`ifdef MUX_SER_PARITY_EN
        check("t6_par_valid", 32'(ser_valid), 32'd1);
        check("t6_par_data",  32'(ser_data),  32'd1);
        check("t6_par_last",  32'(ser_last),  32'd1);
        step();
`endif
        check("t6_done_valid", 32'(ser_valid),  32'd0);
        check("t6_done_ready", 32'(load_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
